// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit for the micro-riscv core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB over a shared datapath and
// decodes the latched instruction into ALU op, immediate format and mux selects.
// Illegal encodings (and memory timeouts when MEM_WAIT_MAX > 0) park in TRAP;
// SYSTEM parks in HALT. Both are left only through reset.
// Optional build macro: CPU_CTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.

package cpu_ctrl_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_ALSU   = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_SB = 3'd2,
    IMM_U  = 3'd3,
    IMM_UJ = 3'd4
  } imm_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_SRL = 4'd3,
    ALU_SRA = 4'd4,
    ALU_OR  = 4'd5,
    ALU_AND = 4'd6,
    ALU_XOR = 4'd7,
    ALU_EQ  = 4'd8,
    ALU_NE  = 4'd9,
    ALU_LTS = 4'd10,
    ALU_GES = 4'd11
  } alu_op_t;
endpackage

module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        cmp_true,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  imm_sel,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        illegal,
  output logic        halted
`ifdef CPU_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  // ST_RST is the post-reset idle cycle: the first edge with rst_n high moves to FETCH.
  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    K_ALSU, K_IMM, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_LUI, K_AUIPC,
    K_SYSTEM, K_BAD
  } kind_t;

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] wait_next_s;
  logic        wait_hit_s;

  kind_t       dec_kind_s;
  imm_t        dec_imm_s;
  alu_op_t     dec_alu_s;
  logic        dec_a_pc_s;
  logic        dec_b_imm_s;
  logic        rd_nz_s;
  logic        unused_instr_s;

  // Shared funct3 -> ALU op map for register and immediate arithmetic.
  // Returns {legal, op}; use_sub enables the instr[30] ADD/SUB choice.
  function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic use_sub);
    logic [4:0] r;
    r = {1'b0, ALU_ADD};
    case (f3)
      F3_ADD:  r = {1'b1, ((use_sub && alt) ? ALU_SUB : ALU_ADD)};
      F3_SLL:  r = {1'b1, ALU_SLL};
      F3_SR:   r = {1'b1, (alt ? ALU_SRA : ALU_SRL)};
      F3_OR:   r = {1'b1, ALU_OR};
      F3_AND:  r = {1'b1, ALU_AND};
      F3_XOR:  r = {1'b1, ALU_XOR};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  assign rd_nz_s        = (instr[11:7] != 5'd0);
  assign unused_instr_s = ^{instr[31], instr[29:15]};

  // Stall counter saturates so a huge MEM_WAIT_MAX can never wrap back to zero.
  assign wait_next_s = (wait_q == 16'hFFFF) ? wait_q : (wait_q + 16'd1);
  assign wait_hit_s  = (MEM_WAIT_MAX != 32'd0) &&
                       (({16'd0, wait_q} + 32'd1) >= MEM_WAIT_MAX);

  // Instruction decode: classify opcode, pick immediate format and ALU controls.
  always_comb begin
    logic [4:0] ar;
    ar          = 5'd0;
    dec_kind_s  = K_BAD;
    dec_imm_s   = IMM_I;
    dec_alu_s   = ALU_ADD;
    dec_a_pc_s  = 1'b0;
    dec_b_imm_s = 1'b0;
    case (instr[6:0])
      OPC_ALSU: begin
        ar         = arith_op(instr[14:12], instr[30], 1'b1);
        dec_alu_s  = alu_op_t'(ar[3:0]);
        dec_kind_s = ar[4] ? K_ALSU : K_BAD;
      end
      OPC_IMM: begin
        ar          = arith_op(instr[14:12], instr[30], 1'b0);
        dec_alu_s   = alu_op_t'(ar[3:0]);
        dec_b_imm_s = 1'b1;
        dec_kind_s  = ar[4] ? K_IMM : K_BAD;
      end
      OPC_LOAD: begin
        dec_b_imm_s = 1'b1;
        dec_kind_s  = (instr[14:12] == F3_LW) ? K_LOAD : K_BAD;
      end
      OPC_STORE: begin
        dec_imm_s   = IMM_S;
        dec_b_imm_s = 1'b1;
        dec_kind_s  = (instr[14:12] == F3_LW) ? K_STORE : K_BAD;
      end
      OPC_BRANCH: begin
        dec_imm_s  = IMM_SB;
        dec_kind_s = K_BRANCH;
        case (instr[14:12])
          F3_BEQ:  dec_alu_s = ALU_EQ;
          F3_BNE:  dec_alu_s = ALU_NE;
          F3_BLT:  dec_alu_s = ALU_LTS;
          F3_BGE:  dec_alu_s = ALU_GES;
          default: dec_kind_s = K_BAD;
        endcase
      end
      OPC_JAL: begin
        dec_imm_s  = IMM_UJ;
        dec_kind_s = K_JAL;
      end
      OPC_JALR: begin
        dec_b_imm_s = 1'b1;
        dec_kind_s  = (instr[14:12] == F3_JALR) ? K_JALR : K_BAD;
      end
      OPC_LUI: begin
        dec_imm_s  = IMM_U;
        dec_kind_s = K_LUI;
      end
      OPC_AUIPC: begin
        dec_imm_s   = IMM_U;
        dec_a_pc_s  = 1'b1;
        dec_b_imm_s = 1'b1;
        dec_kind_s  = K_AUIPC;
      end
      OPC_SYSTEM: dec_kind_s = K_SYSTEM;
      default:    dec_kind_s = K_BAD;
    endcase
  end

  // State register and memory-stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      wait_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and control strobes; everything is held at 0 while rst_n is low.
  always_comb begin
    state_d      = state_q;
    wait_d       = 16'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    imm_sel      = 3'd0;
    alu_op       = 4'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;
    if (!rst_n) begin
      state_d = ST_RST;
    end else begin
      // Post-decode states keep ALU inputs stable, including across MEM stalls.
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        imm_sel   = dec_imm_s;
        alu_op    = dec_alu_s;
        alu_a_sel = dec_a_pc_s;
        alu_b_sel = dec_b_imm_s;
      end else begin
        imm_sel   = 3'd0;
      end
      case (state_q)
        ST_RST: state_d = ST_FETCH;
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (wait_hit_s) begin
            state_d = ST_TRAP;
          end else begin
            wait_d  = wait_next_s;
          end
        end
        ST_DECODE: begin
          imm_sel = dec_imm_s;
          if (dec_kind_s == K_BAD) begin
            state_d = ST_TRAP;
          end else if (dec_kind_s == K_SYSTEM) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (dec_kind_s)
            K_LOAD, K_STORE: state_d = ST_MEM;
            K_BRANCH: begin
              pc_we   = 1'b1;
              pc_sel  = cmp_true ? 2'd2 : 2'd0;
              state_d = ST_FETCH;
            end
            default: state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (dec_kind_s == K_STORE);
          if (mem_ready) begin
            if (dec_kind_s == K_STORE) begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (wait_hit_s) begin
            state_d = ST_TRAP;
          end else begin
            wait_d  = wait_next_s;
          end
        end
        ST_WB: begin
          rf_we   = rd_nz_s;
          pc_we   = 1'b1;
          state_d = ST_FETCH;
          case (dec_kind_s)
            K_LOAD:        wb_sel = 2'd1;
            K_JAL, K_JALR: wb_sel = 2'd2;
            K_LUI:         wb_sel = 2'd3;
            default:       wb_sel = 2'd0;
          endcase
          case (dec_kind_s)
            K_JAL:   pc_sel = 2'd2;
            K_JALR:  pc_sel = 2'd1;
            default: pc_sel = 2'd0;
          endcase
        end
        ST_TRAP: illegal = 1'b1;
        ST_HALT: halted  = 1'b1;
        default: state_d = ST_TRAP;
      endcase
    end
  end

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_cnt_q;

  // Cycle and retired-instruction counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      if (state_q != ST_TRAP && state_q != ST_HALT) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end else begin
        cycle_cnt_q <= cycle_cnt_q;
      end
      if (pc_we) begin
        instret_cnt_q <= instret_cnt_q + 32'd1;
      end else begin
        instret_cnt_q <= instret_cnt_q;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm. The stimulus process drives inputs after
// each rising edge and queues the expected control vector for that cycle; a
// monitor pops and compares on the falling edge. u_dut uses the default
// MEM_WAIT_MAX (wait forever), u_dutw uses MEM_WAIT_MAX=4.
module tb_cpu_ctrl_fsm;

  localparam int IMM_I = 0, IMM_S = 1, IMM_SB = 2, IMM_U = 3, IMM_UJ = 4;
  localparam int A_ADD = 0, A_SUB = 1, A_SRA = 4, A_EQ = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic [3:0] alu_op;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       illegal;
    logic       halted;
  } ctl_t;

  typedef struct {
    string name;
    logic  sel;
    ctl_t  exp;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_ready, cmp_true;
  logic [31:0] instr;
  logic        rst_w, rdy_w, cmp_w;
  logic [31:0] instr_w;

  logic       req0, we0, as0, ir0, pcwe0, rfwe0, a0, b0, ill0, hlt0;
  logic [1:0] pcs0, wbs0;
  logic [2:0] imm0;
  logic [3:0] alu0;
  logic       req1, we1, as1, ir1, pcwe1, rfwe1, a1, b1, ill1, hlt1;
  logic [1:0] pcs1, wbs1;
  logic [2:0] imm1;
  logic [3:0] alu1;
`ifdef CPU_CTRL_PERF_CNT_EN
  logic [31:0] cyc0, ret0, cyc1, ret1;
`endif

  cpu_ctrl_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .cmp_true(cmp_true),
    .mem_req(req0), .mem_we(we0), .mem_addr_sel(as0), .ir_we(ir0), .pc_we(pcwe0),
    .pc_sel(pcs0), .rf_we(rfwe0), .wb_sel(wbs0), .imm_sel(imm0), .alu_op(alu0),
    .alu_a_sel(a0), .alu_b_sel(b0), .illegal(ill0), .halted(hlt0)
`ifdef CPU_CTRL_PERF_CNT_EN
    , .cycle_cnt(cyc0), .instret_cnt(ret0)
`endif
  );

  cpu_ctrl_fsm #(.MEM_WAIT_MAX(4)) u_dutw (
    .clk(clk), .rst_n(rst_w), .instr(instr_w), .mem_ready(rdy_w), .cmp_true(cmp_w),
    .mem_req(req1), .mem_we(we1), .mem_addr_sel(as1), .ir_we(ir1), .pc_we(pcwe1),
    .pc_sel(pcs1), .rf_we(rfwe1), .wb_sel(wbs1), .imm_sel(imm1), .alu_op(alu1),
    .alu_a_sel(a1), .alu_b_sel(b1), .illegal(ill1), .halted(hlt1)
`ifdef CPU_CTRL_PERF_CNT_EN
    , .cycle_cnt(cyc1), .instret_cnt(ret1)
`endif
  );

  ctl_t obs0, obs1;
  assign obs0 = {req0, we0, as0, ir0, pcwe0, pcs0, rfwe0, wbs0, imm0, alu0, a0, b0, ill0, hlt0};
  assign obs1 = {req1, we1, as1, ir1, pcwe1, pcs1, rfwe1, wbs1, imm1, alu1, a1, b1, ill1, hlt1};

  sb_t  exp_q[$];
  sb_t  cur;
  ctl_t got;
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor: one queued expectation per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      got = cur.sel ? obs1 : obs0;
      n_vec++;
      if (got !== cur.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", cur.name, got, cur.exp);
      end
    end
  end

  function automatic ctl_t mk(input int req, we, asel, ir, pcwe, pcs, rfwe, wbs,
                              imm, alu, a, b, ill, hlt);
    ctl_t c;
    c.mem_req = req[0];   c.mem_we = we[0];    c.mem_addr_sel = asel[0];
    c.ir_we = ir[0];      c.pc_we = pcwe[0];   c.pc_sel = pcs[1:0];
    c.rf_we = rfwe[0];    c.wb_sel = wbs[1:0]; c.imm_sel = imm[2:0];
    c.alu_op = alu[3:0];  c.alu_a_sel = a[0];  c.alu_b_sel = b[0];
    c.illegal = ill[0];   c.halted = hlt[0];
    return c;
  endfunction

  ctl_t Z, FET, FSTALL, ILL, HLT;

  task automatic chk(input string nm, input ctl_t e);
    exp_q.push_back('{name: nm, sel: 1'b0, exp: e});
    @(posedge clk); #1;
  endtask

  task automatic chkw(input string nm, input ctl_t e);
    exp_q.push_back('{name: nm, sel: 1'b1, exp: e});
    @(posedge clk); #1;
  endtask

  // Watchdog: the run is a few hundred cycles; this bound cannot be hit normally.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    Z      = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    FET    = mk(1,0,0,1,0,0,0,0,0,0,0,0,0,0);
    FSTALL = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    ILL    = mk(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
    HLT    = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1);

    rst_n = 1'b0; instr = 32'h002081B3; mem_ready = 1'b1; cmp_true = 1'b1;
    rst_w = 1'b0; instr_w = 32'h0040A283; rdy_w = 1'b0; cmp_w = 1'b0;
    @(posedge clk); #1;

    // Reset holds every output low even with active inputs
    chk("reset0", Z);
    chk("reset1", Z);
    rst_n = 1'b1;
    chk("reset_release", Z);

    // add x3,x1,x2 (mem_ready stays high outside FETCH and must be ignored)
    chk("add_fetch", FET);
    chk("add_decode", Z);
    chk("add_exec", Z);
    chk("add_wb", mk(0,0,0,0,1,0,1,0,IMM_I,A_ADD,0,0,0,0));

    // sub x3,x1,x2
    instr = 32'h402081B3;
    chk("sub_fetch", FET);
    chk("sub_decode", Z);
    chk("sub_exec", mk(0,0,0,0,0,0,0,0,IMM_I,A_SUB,0,0,0,0));
    chk("sub_wb", mk(0,0,0,0,1,0,1,0,IMM_I,A_SUB,0,0,0,0));

    // lw x5,4(x1) with three stall cycles in MEM
    instr = 32'h0040A283;
    chk("lw_fetch", FET);
    chk("lw_decode", Z);
    chk("lw_exec", mk(0,0,0,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) chk("lw_mem_stall", mk(1,0,1,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    mem_ready = 1'b1;
    chk("lw_mem_ready", mk(1,0,1,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    chk("lw_wb", mk(0,0,0,0,1,0,1,1,IMM_I,A_ADD,0,1,0,0));

    // beq x0,x0,+8 taken then not taken
    instr = 32'h00000463; cmp_true = 1'b1;
    chk("beq_fetch", FET);
    chk("beq_decode", mk(0,0,0,0,0,0,0,0,IMM_SB,0,0,0,0,0));
    chk("beq_exec_taken", mk(0,0,0,0,1,2,0,0,IMM_SB,A_EQ,0,0,0,0));
    cmp_true = 1'b0;
    chk("beq2_fetch", FET);
    chk("beq2_decode", mk(0,0,0,0,0,0,0,0,IMM_SB,0,0,0,0,0));
    chk("beq_exec_not_taken", mk(0,0,0,0,1,0,0,0,IMM_SB,A_EQ,0,0,0,0));

    // sw x5,4(x1) zero-wait
    instr = 32'h0050A223;
    chk("sw_fetch", FET);
    chk("sw_decode", mk(0,0,0,0,0,0,0,0,IMM_S,0,0,0,0,0));
    chk("sw_exec", mk(0,0,0,0,0,0,0,0,IMM_S,A_ADD,0,1,0,0));
    chk("sw_mem", mk(1,1,1,0,1,0,0,0,IMM_S,A_ADD,0,1,0,0));

    // jal x1,+8
    instr = 32'h008000EF;
    chk("jal_fetch", FET);
    chk("jal_decode", mk(0,0,0,0,0,0,0,0,IMM_UJ,0,0,0,0,0));
    chk("jal_exec", mk(0,0,0,0,0,0,0,0,IMM_UJ,0,0,0,0,0));
    chk("jal_wb", mk(0,0,0,0,1,2,1,2,IMM_UJ,0,0,0,0,0));

    // lui x0: rd == 0 suppresses rf_we
    instr = 32'h12345037;
    chk("lui_fetch", FET);
    chk("lui_decode", mk(0,0,0,0,0,0,0,0,IMM_U,0,0,0,0,0));
    chk("lui_exec", mk(0,0,0,0,0,0,0,0,IMM_U,0,0,0,0,0));
    chk("lui_x0_wb", mk(0,0,0,0,1,0,0,3,IMM_U,0,0,0,0,0));

    // auipc x3
    instr = 32'h00000197;
    chk("auipc_fetch", FET);
    chk("auipc_decode", mk(0,0,0,0,0,0,0,0,IMM_U,0,0,0,0,0));
    chk("auipc_exec", mk(0,0,0,0,0,0,0,0,IMM_U,A_ADD,1,1,0,0));
    chk("auipc_wb", mk(0,0,0,0,1,0,1,0,IMM_U,A_ADD,1,1,0,0));

    // jalr x1,0(x1)
    instr = 32'h000080E7;
    chk("jalr_fetch", FET);
    chk("jalr_decode", Z);
    chk("jalr_exec", mk(0,0,0,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    chk("jalr_wb", mk(0,0,0,0,1,1,1,2,IMM_I,A_ADD,0,1,0,0));

    // srai x5,x1,3 then addi with instr[30] set (must stay ADD)
    instr = 32'h4030D293;
    chk("srai_fetch", FET);
    chk("srai_decode", Z);
    chk("srai_exec", mk(0,0,0,0,0,0,0,0,IMM_I,A_SRA,0,1,0,0));
    chk("srai_wb", mk(0,0,0,0,1,0,1,0,IMM_I,A_SRA,0,1,0,0));
    instr = 32'h40008293;
    chk("addi_fetch", FET);
    chk("addi_decode", Z);
    chk("addi_b30_exec", mk(0,0,0,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    chk("addi_wb", mk(0,0,0,0,1,0,1,0,IMM_I,A_ADD,0,1,0,0));

    // slt traps; illegal is sticky and strobe-free until reset
    instr = 32'h0020A1B3; cmp_true = 1'b1;
    chk("slt_fetch", FET);
    chk("slt_decode", Z);
    for (int i = 0; i < 20; i++) chk("trap_hold", ILL);
    rst_n = 1'b0;
    chk("trap_reset", Z);
    rst_n = 1'b1;
    chk("trap_reset_release", Z);

    // bltu (funct3 110) traps after decode
    instr = 32'h00006463;
    chk("bltu_fetch", FET);
    chk("bltu_decode", mk(0,0,0,0,0,0,0,0,IMM_SB,0,0,0,0,0));
    chk("bltu_trap", ILL);
    chk("bltu_trap2", ILL);
    rst_n = 1'b0;
    chk("bltu_reset", Z);
    rst_n = 1'b1;
    chk("bltu_release", Z);

    // ecall halts
    instr = 32'h00000073;
    chk("ecall_fetch", FET);
    chk("ecall_decode", Z);
    for (int i = 0; i < 3; i++) chk("halt_hold", HLT);
    rst_n = 1'b0;
    chk("halt_reset", Z);
    rst_n = 1'b1;
    chk("halt_release", Z);

    // reset during a stalled load, then FETCH waits indefinitely
    instr = 32'h0040A283; cmp_true = 1'b0;
    chk("lw2_fetch", FET);
    chk("lw2_decode", Z);
    chk("lw2_exec", mk(0,0,0,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    mem_ready = 1'b0;
    chk("lw2_mem_stall", mk(1,0,1,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    chk("lw2_mem_stall", mk(1,0,1,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    rst_n = 1'b0;
    chk("midmem_reset", Z);
    rst_n = 1'b1;
    chk("midmem_release", Z);
    for (int i = 0; i < 6; i++) chk("fetch_wait_forever", FSTALL);
    mem_ready = 1'b1;
    chk("fetch_after_wait", FET);
    chk("decode_after_wait", Z);

    // MEM_WAIT_MAX=4 instance: stalls below the limit, counter clears per state
    chkw("w_reset", Z);
    rst_w = 1'b1;
    chkw("w_release", Z);
    for (int i = 0; i < 3; i++) chkw("w_fetch_stall", FSTALL);
    rdy_w = 1'b1;
    chkw("w_fetch", FET);
    chkw("w_decode", Z);
    chkw("w_exec", mk(0,0,0,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    rdy_w = 1'b0;
    for (int i = 0; i < 3; i++) chkw("w_mem_stall", mk(1,0,1,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    rdy_w = 1'b1;
    chkw("w_mem_ready", mk(1,0,1,0,0,0,0,0,IMM_I,A_ADD,0,1,0,0));
    chkw("w_wb", mk(0,0,0,0,1,0,1,1,IMM_I,A_ADD,0,1,0,0));
    rdy_w = 1'b0;
    for (int i = 0; i < 4; i++) chkw("w_fetch_timeout_stall", FSTALL);
    for (int i = 0; i < 3; i++) chkw("w_timeout_trap", ILL);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit for the micro-riscv core. It sequences the shared datapath (PC, IR, register file, ALU, single memory port) through fetch, decode, execute, memory and writeback. It decodes the latched instruction into ALU op, immediate format and mux selects using the package opcode, funct3, imm_t and alu_op_t definitions. Illegal encodings trap; SYSTEM halts the core.

Parameters:
MEM_WAIT_MAX, 0, max cycles waiting on mem_ready before trapping; 0 = wait forever

Ports:
clk  in  1  core clock
rst_n  in  1  reset; one clock, synchronous, active-low
instr  in  32  IR contents; valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
cmp_true  in  1  ALU result bit 0 for compare ops
mem_req  out  1  memory access request
mem_we  out  1  store when 1
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR from mem rdata
pc_we  out  1  update PC
pc_sel  out  2  0 = PC+4, 1 = ALU result with bit0 cleared, 2 = PC+imm
rf_we  out  1  register file write
wb_sel  out  2  0 = ALU, 1 = mem rdata, 2 = PC+4, 3 = imm
imm_sel  out  3  imm_t
alu_op  out  4  alu_op_t
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = imm
illegal  out  1  sticky trap flag
halted  out  1  sticky halt flag

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT. Outputs are combinational from state, instr, mem_ready and cmp_true. All strobes are 0 when not listed for a state.
- Reset: while rst_n is low, every output is 0. On the first edge with rst_n high, state = FETCH. A reset in any state, including mid-access, drops mem_req at the next edge and clears illegal and halted.
- FETCH: mem_req=1, mem_addr_sel=0. Hold until mem_ready. In the mem_ready cycle ir_we=1, then go to DECODE.
- DECODE: one cycle for register read; imm_sel is driven. Unsupported opcode or funct3 goes to TRAP. OPC_SYSTEM goes to HALT. Everything else goes to EXEC.
- imm_sel by opcode: LOAD/IMM/JALR = IMM_I; STORE = IMM_S; BRANCH = IMM_SB; LUI/AUIPC = IMM_U; JAL = IMM_UJ.
- ALSU alu_op from funct3: ADD, or SUB if instr[30]; SLL; SRL, or SRA if instr[30]; OR; AND; XOR.
- IMM alu_op: same mapping, but ADD ignores instr[30]. Immediate shifts use instr[30] to select SRA.
- Other funct3 values (010, 011) trap.
- LOAD/STORE: funct3 must equal F3_LW, else trap.
- BRANCH alu_op: BEQ = EQ, BNE = NE, BLT = LTS, BGE = GES. 110 and 111 trap.
- EXEC, ALSU: alu_b_sel=0, then go to WB.
- EXEC, IMM: alu_b_sel=1, then go to WB.
- EXEC, AUIPC: alu_a_sel=1, alu_b_sel=1, ALU_ADD, then go to WB.
- EXEC, LUI: no ALU work, then go to WB.
- EXEC, LOAD/STORE: ALU_ADD, alu_b_sel=1, then go to MEM.
- EXEC, BRANCH: compare op, pc_we=1, pc_sel = cmp_true ? 2 : 0, then go to FETCH.
- EXEC, JAL/JALR: JALR computes ALU_ADD with alu_b_sel=1, then go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. Hold until mem_ready; ALU inputs are held stable while waiting. On mem_ready, a STORE does pc_we=1 with pc_sel=0 and goes to FETCH; a LOAD goes to WB.
- WB: rf_we=1 when instr[11:7] != 0. pc_we=1 and go to FETCH.
- WB wb_sel: LOAD = 1; JAL/JALR = 2; LUI = 3; otherwise 0.
- WB pc_sel: JAL = 2; JALR = 1; otherwise 0.
- TRAP/HALT: absorbing states. Respectively illegal=1 or halted=1; no strobes until reset.
- mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory (mem_ready in the request cycle): R/I/U-type and jumps 4 cycles; load 5; store 4; branch 3.
- MEM_WAIT_MAX > 0: a 16-bit wait counter increments each stalled cycle in FETCH/MEM and clears on state change. When it reaches MEM_WAIT_MAX, go to TRAP.

Optional Feature:
Macro CPU_CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0. cycle_cnt increments every non-reset cycle outside TRAP/HALT. instret_cnt increments on each pc_we. Both wrap modulo 2^32.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then zero-wait memory, instr=0x002081B3 (add x3,x1,x2) -> FETCH/DECODE/EXEC/WB in 4 cycles; alu_op=ALU_ADD, rf_we=1, wb_sel=0, pc_sel=0; back in FETCH on cycle 5.
- instr=0x402081B3 -> alu_op=ALU_SUB. instr=0x0040A283 (lw x5,4(x1)) with mem_ready delayed 3 cycles in MEM -> mem_req/mem_addr_sel=1 held 4 cycles; then WB with wb_sel=1, rf_we=1.
- instr=0x00000463 (beq x0,x0,+8), cmp_true=1 -> imm_sel=IMM_SB, alu_op=ALU_EQ, pc_we=1, pc_sel=2 in EXEC; cmp_true=0 -> pc_sel=0; 3 cycles total.
- instr=0x0020A1B3 (slt) -> TRAP after DECODE; illegal=1 stays high with no strobes for 20 cycles; rst_n low for 1 cycle clears it.
- instr=0x00000073 (ecall) -> halted=1; rst_n asserted during MEM of a stalled load -> mem_req=0 after that edge, state FETCH.
- MEM_WAIT_MAX=4 with mem_ready stuck at 0 in FETCH -> illegal=1 after the 4th stall cycle.
